// File: rtl/rv_ctrl_pkg.sv
// Shared RV32 decode definitions: opcode values, ALU op codes, branch
// condition codes and the control bundle carried by the decode stage.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_NOP  = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SLTU = 3'd5;
    localparam logic [2:0] ALU_OR   = 3'd6;
    localparam logic [2:0] ALU_AND  = 3'd7;

    localparam logic [2:0] BR_EQ = 3'b000;
    localparam logic [2:0] BR_NE = 3'b001;
    localparam logic [2:0] BR_LT = 3'b100;
    localparam logic [2:0] BR_GE = 3'b101;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       rf_we;
        logic       has_imm;
        logic       mem_we;
        logic       mem_re;
        logic       branch;
        logic       jump;
        logic [2:0] br_cond;
        logic       illegal;
    } ctrl_t;

    // Maps funct3 of the supported ALU instructions (ADD/XOR/OR/AND and
    // their immediate forms) onto the ALU op codes.
    function automatic logic [2:0] alu_from_f3(input logic [2:0] f3);
        logic [2:0] op;
        op = ALU_NOP;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b100:  op = ALU_XOR;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32 subset decoder.
//   instr            : 32-bit instruction word
//   ctrl             : control bundle (illegal=1 with all controls 0 if unsupported)
//   imm              : sign-extended immediate (U-type already shifted by 12)
//   rs1/rs2/rd       : register fields (rs1 forced to 0 for LUI)
//   uses_rs1/uses_rs2: instruction actually reads that source register
module instr_decoder
    import rv_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm,
    output logic [RA_W-1:0] rs1,
    output logic [RA_W-1:0] rs2,
    output logic [RA_W-1:0] rd,
    output logic            uses_rs1,
    output logic            uses_rs2
);

    logic [6:0]         opcode;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic signed [31:0] imm32;
    logic               legal;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    assign rs1 = (opcode == OPC_LUI) ? '0 : RA_W'(instr[19:15]);
    assign rs2 = RA_W'(instr[24:20]);
    assign rd  = RA_W'(instr[11:7]);

    // Signed cast sign-extends the 32-bit immediate up to XLEN.
    assign imm = XLEN'(imm32);

    always_comb begin
        ctrl     = '0;
        imm32    = '0;
        legal    = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                if (f3 inside {3'b000, 3'b100, 3'b110, 3'b111}) begin
                    legal        = 1'b1;
                    ctrl.alu_op  = alu_from_f3(f3);
                    ctrl.rf_we   = 1'b1;
                    ctrl.has_imm = 1'b1;
                    imm32        = {{20{instr[31]}}, instr[31:20]};
                    uses_rs1     = 1'b1;
                end
            end
            OPC_OP: begin
                if ((f7 == 7'b0000000 && f3 inside {3'b000, 3'b100, 3'b110, 3'b111}) ||
                    (f7 == 7'b0100000 && f3 == 3'b000)) begin
                    legal       = 1'b1;
                    ctrl.alu_op = (f7[5]) ? ALU_SUB : alu_from_f3(f3);
                    ctrl.rf_we  = 1'b1;
                    uses_rs1    = 1'b1;
                    uses_rs2    = 1'b1;
                end
            end
            OPC_LOAD: begin
                if (f3 == 3'b010) begin
                    legal        = 1'b1;
                    ctrl.alu_op  = ALU_ADD;
                    ctrl.has_imm = 1'b1;
                    ctrl.mem_re  = 1'b1;
                    ctrl.rf_we   = 1'b1;
                    imm32        = {{20{instr[31]}}, instr[31:20]};
                    uses_rs1     = 1'b1;
                end
            end
            OPC_STORE: begin
                if (f3 == 3'b010) begin
                    legal        = 1'b1;
                    ctrl.alu_op  = ALU_ADD;
                    ctrl.has_imm = 1'b1;
                    ctrl.mem_we  = 1'b1;
                    imm32        = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                    uses_rs1     = 1'b1;
                    uses_rs2     = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (f3 inside {BR_EQ, BR_NE, BR_LT, BR_GE}) begin
                    legal        = 1'b1;
                    ctrl.alu_op  = ALU_SUB;
                    ctrl.branch  = 1'b1;
                    ctrl.br_cond = f3;
                    imm32        = {{20{instr[31]}}, instr[7], instr[30:25],
                                    instr[11:8], 1'b0};
                    uses_rs1     = 1'b1;
                    uses_rs2     = 1'b1;
                end
            end
            OPC_LUI: begin
                legal        = 1'b1;
                ctrl.alu_op  = ALU_ADD;
                ctrl.has_imm = 1'b1;
                ctrl.rf_we   = 1'b1;
                imm32        = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                legal      = 1'b1;
                ctrl.jump  = 1'b1;
                ctrl.rf_we = 1'b1;
                imm32      = {{12{instr[31]}}, instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32 decode stage between fetch and execute.
//   clk, rst             : clock, synchronous active-high reset
//   flush                : drop held and incoming instruction (redirect)
//   in_valid/in_ready    : fetch handshake, in_instr/in_pc payload
//   out_valid/out_ready  : execute handshake
//   out_pc, out_imm      : PC and sign-extended immediate of the bundle
//   out_rs1/rs2/rd       : register fields
//   out_alu_op .. out_illegal : decoded control bundle
//   ill_count            : saturating count of illegal bundles delivered
module decode_stage
    import rv_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RA_W      = 5,
    parameter int ILL_CNT_W = 8,
    parameter bit HAZ_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_imm,
    output logic [RA_W-1:0]      out_rs1,
    output logic [RA_W-1:0]      out_rs2,
    output logic [RA_W-1:0]      out_rd,
    output logic [2:0]           out_alu_op,
    output logic                 out_rf_we,
    output logic                 out_has_imm,
    output logic                 out_mem_we,
    output logic                 out_mem_re,
    output logic                 out_branch,
    output logic                 out_jump,
    output logic [2:0]           out_br_cond,
    output logic                 out_illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic [RA_W-1:0] dec_rs1, dec_rs2, dec_rd;
    logic            dec_uses_rs1, dec_uses_rs2;

    instr_decoder #(.XLEN(XLEN), .RA_W(RA_W)) u_dec (
        .instr    (in_instr),
        .ctrl     (dec_ctrl),
        .imm      (dec_imm),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rd       (dec_rd),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2)
    );

    logic                 out_valid_reg;
    ctrl_t                ctrl_reg;
    logic [XLEN-1:0]      pc_reg, imm_reg;
    logic [RA_W-1:0]      rs1_reg, rs2_reg, rd_reg;
    logic                 haz_vld_reg;
    logic [RA_W-1:0]      haz_rd_reg;
    logic [ILL_CNT_W-1:0] ill_count_reg;

    logic stall, xfer_in, xfer_out;

    // A load still sitting in the output register (or just leaving it) must
    // not be followed directly by a consumer of its rd: the consumer is held
    // back one cycle, which lets a bubble reach execute in between.
    assign stall = HAZ_EN && haz_vld_reg && in_valid &&
                   ((dec_uses_rs1 && dec_rs1 == haz_rd_reg) ||
                    (dec_uses_rs2 && dec_rs2 == haz_rd_reg));

    assign in_ready = (!out_valid_reg || out_ready) && !stall && !flush;
    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = out_valid_reg && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            ctrl_reg      <= '0;
            pc_reg        <= '0;
            imm_reg       <= '0;
            rs1_reg       <= '0;
            rs2_reg       <= '0;
            rd_reg        <= '0;
            haz_vld_reg   <= 1'b0;
            haz_rd_reg    <= '0;
            ill_count_reg <= '0;
        end else begin
            if (flush) begin
                out_valid_reg <= 1'b0;
            end else if (xfer_in) begin
                out_valid_reg <= 1'b1;
            end else if (xfer_out) begin
                out_valid_reg <= 1'b0;
            end

            if (xfer_in) begin
                ctrl_reg <= dec_ctrl;
                pc_reg   <= in_pc;
                imm_reg  <= dec_imm;
                rs1_reg  <= dec_rs1;
                rs2_reg  <= dec_rs2;
                rd_reg   <= dec_rd;
            end

            // Hazard window opens when a load with rd!=0 is captured, stays
            // open while execute holds it off, and closes one cycle after it
            // has been handed over.
            if (flush) begin
                haz_vld_reg <= 1'b0;
            end else if (xfer_in) begin
                haz_vld_reg <= dec_ctrl.mem_re && (dec_rd != '0);
                haz_rd_reg  <= dec_rd;
            end else if (!(out_valid_reg && !out_ready)) begin
                haz_vld_reg <= 1'b0;
            end

            if (xfer_out && ctrl_reg.illegal && (ill_count_reg != '1)) begin
                ill_count_reg <= ill_count_reg + 1'b1;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_pc      = pc_reg;
    assign out_imm     = imm_reg;
    assign out_rs1     = rs1_reg;
    assign out_rs2     = rs2_reg;
    assign out_rd      = rd_reg;
    assign out_alu_op  = ctrl_reg.alu_op;
    assign out_rf_we   = ctrl_reg.rf_we;
    assign out_has_imm = ctrl_reg.has_imm;
    assign out_mem_we  = ctrl_reg.mem_we;
    assign out_mem_re  = ctrl_reg.mem_re;
    assign out_branch  = ctrl_reg.branch;
    assign out_jump    = ctrl_reg.jump;
    assign out_br_cond = ctrl_reg.br_cond;
    assign out_illegal = ctrl_reg.illegal;
    assign ill_count   = ill_count_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one instance with load-use stalling,
// one with it disabled, sharing clock, instruction and PC.
module tb_decode_stage;

    localparam int XLEN      = 32;
    localparam int RA_W      = 5;
    localparam int ILL_CNT_W = 8;

    localparam logic [31:0] I_ADDI = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] I_BNE  = 32'hFE209EE3; // bne x1,x2,-4
    localparam logic [31:0] I_LUI  = 32'h123451B7; // lui x3,0x12345
    localparam logic [31:0] I_SW   = 32'h0020A423; // sw x2,8(x1)
    localparam logic [31:0] I_SUB  = 32'h402083B3; // sub x7,x1,x2
    localparam logic [31:0] I_JAL  = 32'h010000EF; // jal x1,+16
    localparam logic [31:0] I_LW   = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] I_ADD  = 32'h00028333; // add x6,x5,x0
    localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;

    logic clk = 1'b0;
    logic rst, flush, in_valid, nh_in_valid, out_ready, nh_out_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic                 in_ready, out_valid;
    logic [XLEN-1:0]      out_pc, out_imm;
    logic [RA_W-1:0]      out_rs1, out_rs2, out_rd;
    logic [2:0]           out_alu_op, out_br_cond;
    logic                 out_rf_we, out_has_imm, out_mem_we, out_mem_re;
    logic                 out_branch, out_jump, out_illegal;
    logic [ILL_CNT_W-1:0] ill_count;

    logic                 nh_in_ready, nh_out_valid;
    logic [XLEN-1:0]      nh_out_pc, nh_out_imm;
    logic [RA_W-1:0]      nh_out_rs1, nh_out_rs2, nh_out_rd;
    logic [2:0]           nh_out_alu_op, nh_out_br_cond;
    logic                 nh_out_rf_we, nh_out_has_imm, nh_out_mem_we, nh_out_mem_re;
    logic                 nh_out_branch, nh_out_jump, nh_out_illegal;
    logic [ILL_CNT_W-1:0] nh_ill_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ill  = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .RA_W(RA_W), .ILL_CNT_W(ILL_CNT_W), .HAZ_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_alu_op(out_alu_op),
        .out_rf_we(out_rf_we), .out_has_imm(out_has_imm), .out_mem_we(out_mem_we),
        .out_mem_re(out_mem_re), .out_branch(out_branch), .out_jump(out_jump),
        .out_br_cond(out_br_cond), .out_illegal(out_illegal), .ill_count(ill_count)
    );

    decode_stage #(.XLEN(XLEN), .RA_W(RA_W), .ILL_CNT_W(ILL_CNT_W), .HAZ_EN(1'b0)) dut_nh (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(nh_in_valid), .in_ready(nh_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(nh_out_valid), .out_ready(nh_out_ready), .out_pc(nh_out_pc),
        .out_imm(nh_out_imm), .out_rs1(nh_out_rs1), .out_rs2(nh_out_rs2), .out_rd(nh_out_rd),
        .out_alu_op(nh_out_alu_op), .out_rf_we(nh_out_rf_we), .out_has_imm(nh_out_has_imm),
        .out_mem_we(nh_out_mem_we), .out_mem_re(nh_out_mem_re), .out_branch(nh_out_branch),
        .out_jump(nh_out_jump), .out_br_cond(nh_out_br_cond), .out_illegal(nh_out_illegal),
        .ill_count(nh_ill_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [XLEN-1:0] pc, input string tag);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        $display("txn %s pc=0x%08h instr=0x%08h", tag, pc, instr);
    endtask

    // Presents one instruction for a single edge, then withdraws it.
    task automatic issue(input logic [31:0] instr, input logic [XLEN-1:0] pc, input string tag);
        present(instr, pc, tag);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; nh_in_valid = 1'b0;
        out_ready = 1'b1; nh_out_ready = 1'b1; in_instr = '0; in_pc = '0;
        step(); step();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_ill_count", ill_count, 0);
        check_eq("rst_out_imm", out_imm, 0);
        check_eq("rst_out_rd", out_rd, 0);
        check_eq("rst_alu_op", out_alu_op, 0);
        rst = 1'b0;
        step();
        check_eq("rst_in_ready", in_ready, 1);

        // ADDI
        issue(I_ADDI, 32'h100, "addi");
        check_eq("addi_valid", out_valid, 1);
        check_eq("addi_rf_we", out_rf_we, 1);
        check_eq("addi_alu", out_alu_op, 1);
        check_eq("addi_has_imm", out_has_imm, 1);
        check_eq("addi_imm", out_imm, 5);
        check_eq("addi_rd", out_rd, 1);
        check_eq("addi_pc", out_pc, 32'h100);
        step();
        check_eq("addi_drain", out_valid, 0);

        // BNE
        issue(I_BNE, 32'h104, "bne");
        check_eq("bne_branch", out_branch, 1);
        check_eq("bne_cond", out_br_cond, 3'b001);
        check_eq("bne_alu", out_alu_op, 2);
        check_eq("bne_imm", out_imm, 32'hFFFFFFFC);
        check_eq("bne_rf_we", out_rf_we, 0);
        check_eq("bne_rs1", out_rs1, 1);
        check_eq("bne_rs2", out_rs2, 2);

        // LUI: rs1 field in the encoding is nonzero but must read 0
        issue(I_LUI, 32'h108, "lui");
        check_eq("lui_imm", out_imm, 32'h12345000);
        check_eq("lui_rs1", out_rs1, 0);
        check_eq("lui_rd", out_rd, 3);
        check_eq("lui_alu", out_alu_op, 1);

        issue(I_SW, 32'h10C, "sw");
        check_eq("sw_mem_we", out_mem_we, 1);
        check_eq("sw_imm", out_imm, 8);
        check_eq("sw_rf_we", out_rf_we, 0);
        check_eq("sw_has_imm", out_has_imm, 1);

        issue(I_SUB, 32'h110, "sub");
        check_eq("sub_alu", out_alu_op, 2);
        check_eq("sub_has_imm", out_has_imm, 0);
        check_eq("sub_rd", out_rd, 7);

        issue(I_JAL, 32'h114, "jal");
        check_eq("jal_jump", out_jump, 1);
        check_eq("jal_rf_we", out_rf_we, 1);
        check_eq("jal_imm", out_imm, 16);

        issue(I_ILL, 32'h118, "illegal");
        check_eq("ill_flag", out_illegal, 1);
        check_eq("ill_rf_we", out_rf_we, 0);
        check_eq("ill_alu", out_alu_op, 0);
        step();
        exp_ill = 1;
        check_eq("ill_count_1", ill_count, exp_ill);

        // Load-use: LW then dependent ADD, both instances
        present(I_LW, 32'h200, "lw");
        nh_in_valid = 1'b1;
        step();
        present(I_ADD, 32'h204, "add");
        check_eq("lw_valid", out_valid, 1);
        check_eq("lw_mem_re", out_mem_re, 1);
        check_eq("nh_lw_pc", nh_out_pc, 32'h200);
        @(negedge clk);
        check_eq("haz_in_ready", in_ready, 0);
        check_eq("nh_in_ready", nh_in_ready, 1);
        step();
        nh_in_valid = 1'b0;
        check_eq("haz_bubble", out_valid, 0);
        check_eq("nh_add_valid", nh_out_valid, 1);
        check_eq("nh_add_pc", nh_out_pc, 32'h204);
        @(negedge clk);
        check_eq("haz_release", in_ready, 1);
        step();
        in_valid = 1'b0;
        check_eq("haz_add_valid", out_valid, 1);
        check_eq("haz_add_pc", out_pc, 32'h204);
        check_eq("haz_add_rd", out_rd, 6);
        step();

        // Downstream backpressure
        out_ready = 1'b0;
        issue(I_ADDI, 32'h300, "addi");
        present(I_SUB, 32'h304, "sub");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("bp_in_ready", in_ready, 0);
            check_eq("bp_valid", out_valid, 1);
            check_eq("bp_pc", out_pc, 32'h300);
            check_eq("bp_alu", out_alu_op, 1);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("bp_next_valid", out_valid, 1);
        check_eq("bp_next_pc", out_pc, 32'h304);
        check_eq("bp_next_alu", out_alu_op, 2);
        step();
        check_eq("bp_drain", out_valid, 0);

        // Flush wins over a pending transfer
        issue(I_ADDI, 32'h400, "addi");
        check_eq("fl_valid", out_valid, 1);
        present(I_SUB, 32'h404, "sub");
        flush = 1'b1;
        @(negedge clk);
        check_eq("fl_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check_eq("fl_out_valid", out_valid, 0);
        step();
        check_eq("fl_no_accept", out_valid, 0);

        // Illegal stream with counter saturation
        present(I_ILL, 32'h800, "illegal_stream");
        for (int i = 1; i <= 260; i++) begin
            step();
            $display("txn illegal #%0d", i);
            check_eq("burst_valid", out_valid, 1);
            check_eq("burst_illegal", out_illegal, 1);
            check_eq("burst_count", ill_count, (exp_ill + i - 1 > 255) ? 255 : exp_ill + i - 1);
        end
        flush = 1'b1;
        @(negedge clk);
        check_eq("burst_fl_ready", in_ready, 0);
        step();
        flush = 1'b0;
        check_eq("burst_fl_valid", out_valid, 0);
        step();
        check_eq("burst_resume", out_valid, 1);
        rst = 1'b1;
        step();
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_count", ill_count, 0);
        check_eq("mid_rst_illegal", out_illegal, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        check_eq("post_rst_ready", in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
